// File: rtl/lbist_ctrl.sv
// ============================================================================
// lbist_ctrl : logic-BIST session sequencer (TPG reset, MISR enable, compare)
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lbist_ctrl #(
   parameter int                  BITS         = 4,
   parameter int                  SIG_BITS     = 8,
   parameter logic [SIG_BITS-1:0] GOLDEN       = '0,
   parameter int                  MAX_PATTERNS = (1 << BITS) - 1,
   parameter int                  CUT_LAT      = 1,
   parameter int                  CW           = $clog2(MAX_PATTERNS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                tpg_end,
   input  logic [SIG_BITS-1:0] signature,
   output logic                tpg_rst,
   output logic                misr_clr,
   output logic                misr_en,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic [CW-1:0]       pattern_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_RUN     = 3'd2,
      S_FLUSH   = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [CW-1:0] LIMIT      = CW'(MAX_PATTERNS);
   localparam logic [CW-1:0] LAST       = CW'(MAX_PATTERNS - 1);
   localparam bit            HAS_FLUSH  = (CUT_LAT > 0);
   localparam logic [3:0]    FLUSH_LOAD = HAS_FLUSH ? 4'(CUT_LAT - 1) : 4'd0;

   if (MAX_PATTERNS < 1 || CUT_LAT < 0 || CUT_LAT > 15) begin : g_param_check
      $error("lbist_ctrl: MAX_PATTERNS must be >= 1 and CUT_LAT within 0..15");
   end

   state_t     state;
   state_t     next_state;
   logic [3:0] flush_cnt;
   logic       in_session;
   logic       last_pattern;
   logic       run_exit;

   always_comb begin
      in_session   = (state == S_INIT) || (state == S_RUN) ||
                     (state == S_FLUSH) || (state == S_COMPARE);
      last_pattern = (pattern_count == LAST);
      run_exit     = tpg_end || last_pattern;
      next_state   = state;
      case (state)
         S_IDLE:    if (start) next_state = S_INIT;
         S_INIT:    next_state = S_RUN;
         S_RUN:     if (run_exit) next_state = HAS_FLUSH ? S_FLUSH : S_COMPARE;
         S_FLUSH:   if (flush_cnt == 4'd0) next_state = S_COMPARE;
         S_COMPARE: next_state = S_DONE;
         S_DONE:    if (start) next_state = S_INIT;
         default:   next_state = S_IDLE;
      endcase
      if (abort && in_session) next_state = S_IDLE;
   end

   // Control outputs are registered from next_state so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         tpg_rst       <= 1'b1;
         misr_clr      <= 1'b0;
         misr_en       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         pattern_count <= '0;
         flush_cnt     <= 4'd0;
      end else begin
         state    <= next_state;
         tpg_rst  <= (next_state != S_RUN);
         misr_clr <= (next_state == S_INIT);
         misr_en  <= (next_state == S_RUN) || (next_state == S_FLUSH);
         busy     <= (next_state == S_INIT) || (next_state == S_RUN) ||
                     (next_state == S_FLUSH) || (next_state == S_COMPARE);
         done     <= (next_state == S_DONE);

         if (abort && in_session) begin
            pass    <= 1'b0;
            timeout <= 1'b0;
         end else begin
            case (state)
               S_INIT: begin
                  pattern_count <= '0;
                  pass          <= 1'b0;
                  timeout       <= 1'b0;
               end
               S_RUN: begin
                  if (pattern_count != LIMIT) pattern_count <= pattern_count + CW'(1);
                  // tpg_end takes precedence when it coincides with the limit
                  if (last_pattern && !tpg_end) timeout <= 1'b1;
                  if (run_exit) flush_cnt <= FLUSH_LOAD;
               end
               S_FLUSH: begin
                  if (flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
               end
               S_COMPARE: begin
                  pass <= (signature == GOLDEN) && !timeout;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lbist_ctrl.sv
// ============================================================================
// tb_lbist_ctrl : directed and randomized session checks on two configurations
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lbist_ctrl;

   localparam int         MAX_A  = 15;
   localparam int         LAT_A  = 1;
   localparam logic [7:0] GOLD_A = 8'hA5;
   localparam int         MAX_B  = 8;
   localparam int         LAT_B  = 0;
   localparam logic [7:0] GOLD_B = 8'h3C;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_s [2];
   logic       abort_s [2];
   logic       end_s   [2];
   logic [7:0] sig_s   [2];
   logic       tpg_rst_w [2];
   logic       misr_clr_w[2];
   logic       misr_en_w [2];
   logic       busy_w    [2];
   logic       done_w    [2];
   logic       pass_w    [2];
   logic       timeout_w [2];
   logic [3:0] pc_w      [2];

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   lbist_ctrl #(.BITS(4), .SIG_BITS(8), .GOLDEN(GOLD_A), .MAX_PATTERNS(MAX_A), .CUT_LAT(LAT_A)) dut_a (
      .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .tpg_end(end_s[0]),
      .signature(sig_s[0]), .tpg_rst(tpg_rst_w[0]), .misr_clr(misr_clr_w[0]),
      .misr_en(misr_en_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .timeout(timeout_w[0]), .pattern_count(pc_w[0])
   );

   lbist_ctrl #(.BITS(4), .SIG_BITS(8), .GOLDEN(GOLD_B), .MAX_PATTERNS(MAX_B), .CUT_LAT(LAT_B)) dut_b (
      .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .tpg_end(end_s[1]),
      .signature(sig_s[1]), .tpg_rst(tpg_rst_w[1]), .misr_clr(misr_clr_w[1]),
      .misr_en(misr_en_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .timeout(timeout_w[1]), .pattern_count(pc_w[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input int which, input string tag);
      check({tag, "_tpg_rst"}, 32'(tpg_rst_w[which]), 32'd1);
      check({tag, "_misr_en"}, 32'(misr_en_w[which]), 32'd0);
      check({tag, "_busy"},    32'(busy_w[which]),    32'd0);
      check({tag, "_done"},    32'(done_w[which]),    32'd0);
      check({tag, "_pass"},    32'(pass_w[which]),    32'd0);
      check({tag, "_timeout"}, 32'(timeout_w[which]), 32'd0);
      check({tag, "_count"},   32'(pc_w[which]),      32'd0);
   endtask

   // One session; entered and left 1 time unit after a rising edge.
   // Edge 0 samples start; RUN cycle j follows edge j; tpg_end pulses in RUN cycle n_end (0 = never).
   task automatic session(input int which, input int n_end, input logic [7:0] sig,
                          input int abort_at, input bit hold);
      int         max_p, lat, n_run, done_edge, last_en, clr_cnt;
      bit         exp_to, any_done, aborted;
      logic [7:0] gold;
      max_p     = (which == 0) ? MAX_A : MAX_B;
      lat       = (which == 0) ? LAT_A : LAT_B;
      gold      = (which == 0) ? GOLD_A : GOLD_B;
      exp_to    = !(n_end >= 1 && n_end <= max_p);
      n_run     = exp_to ? max_p : n_end;
      done_edge = -1;
      last_en   = -1;
      clr_cnt   = 0;
      aborted   = 1'b0;
      any_done  = 1'b0;

      start_s[which] = 1'b1;
      sig_s[which]   = sig;
      end_s[which]   = 1'b0;
      abort_s[which] = 1'b0;
      @(posedge clk); #1;
      if (!hold) start_s[which] = 1'b0;
      check("init_misr_clr", 32'(misr_clr_w[which]), 32'd1);
      check("init_busy",     32'(busy_w[which]),     32'd1);

      for (int e = 1; e <= 60 && done_edge < 0 && !aborted; e++) begin
         @(posedge clk); #1;
         end_s[which]   = (e == n_end);
         abort_s[which] = (e == abort_at);
         if (misr_en_w[which]) last_en = e;
         if (misr_clr_w[which]) clr_cnt++;
         if (e == 1) check("run_tpg_rst", 32'(tpg_rst_w[which]), 32'd0);
         if (e == 2 && abort_at != 1) check("run_count_restart", 32'(pc_w[which]), 32'd1);
         if (done_w[which]) done_edge = e;
         if (abort_at > 0 && e == abort_at + 1) aborted = 1'b1;
      end
      end_s[which]   = 1'b0;
      abort_s[which] = 1'b0;

      if (abort_at > 0) begin
         check("abort_busy",    32'(busy_w[which]),    32'd0);
         check("abort_tpg_rst", 32'(tpg_rst_w[which]), 32'd1);
         check("abort_pass",    32'(pass_w[which]),    32'd0);
         check("abort_timeout", 32'(timeout_w[which]), 32'd0);
         check("abort_count",   32'(pc_w[which]),      32'(abort_at - 1));
         repeat (6) begin
            if (done_w[which]) any_done = 1'b1;
            @(posedge clk); #1;
         end
         check("abort_no_done", 32'(any_done), 32'd0);
      end else begin
         // done rises N + CUT_LAT + 3 cycles after the start cycle, i.e. N + CUT_LAT + 2 edges after edge 0
         check("done_latency",  32'(done_edge),         32'(n_run + lat + 2));
         check("done_count",    32'(pc_w[which]),       32'(n_run));
         check("done_timeout",  32'(timeout_w[which]),  32'(exp_to));
         check("done_pass",     32'(pass_w[which]),     32'((sig == gold) && !exp_to));
         check("last_misr_en",  32'(last_en),           32'(n_run + lat));
         check("single_clr",    32'(clr_cnt),           32'd0);
         check("done_tpg_rst",  32'(tpg_rst_w[which]),  32'd1);
         check("done_busy",     32'(busy_w[which]),     32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         which, max_p, n_end, abort_at, n_run;
      logic [7:0] gold, sig;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         abort_s[i] = 1'b0;
         end_s[i]   = 1'b0;
         sig_s[i]   = 8'h00;
      end

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs(0, "reset_a");
      check_reset_outputs(1, "reset_b");
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle_misr_clr", 32'(misr_clr_w[0]), 32'd0);

      // normal pass, then DONE holds and ignores abort
      session(0, 15, GOLD_A, 0, 1'b0);
      abort_s[0] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      abort_s[0] = 1'b0;
      check("done_hold", 32'(done_w[0]), 32'd1);
      check("done_hold_pass", 32'(pass_w[0]), 32'd1);

      session(0, 15, GOLD_A ^ 8'h01, 0, 1'b0);   // signature mismatch
      session(1, 0, GOLD_B, 0, 1'b0);            // timeout with matching signature
      session(1, 8, GOLD_B, 0, 1'b0);            // limit and tpg_end together
      session(0, 10, GOLD_A, 3, 1'b0);           // abort in 3rd RUN cycle

      // asynchronous reset in FLUSH
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
         end_s[0] = (e == 4);
      end
      end_s[0] = 1'b0;
      check("flush_tpg_rst", 32'(tpg_rst_w[0]), 32'd1);
      check("flush_misr_en", 32'(misr_en_w[0]), 32'd1);
      #2 rst = 1'b0;
      #1 check_reset_outputs(0, "async_rst");
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", 32'(busy_w[0]), 32'd0);

      // back-to-back sessions with start held high
      session(1, 5, GOLD_B, 0, 1'b1);
      session(1, 3, GOLD_B ^ 8'h10, 0, 1'b1);
      session(1, 6, GOLD_B, 0, 1'b0);
      session(0, 4, GOLD_A, 0, 1'b1);
      session(0, 7, GOLD_A, 0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         which = int'($urandom_range(0, 1));
         max_p = (which == 0) ? MAX_A : MAX_B;
         gold  = (which == 0) ? GOLD_A : GOLD_B;
         n_end = int'($urandom_range(0, max_p + 2));
         n_run = (n_end >= 1 && n_end <= max_p) ? n_end : max_p;
         sig   = ($urandom_range(0, 1) == 1) ? gold : (gold ^ (8'h01 << $urandom_range(0, 7)));
         abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n_run)) : 0;
         session(which, n_end, sig, abort_at, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
